conv_serializer: RTL and testbench
==================================

CONV_SERIALIZER -- requirements
Module: conv_serializer

Interface
REQ-001 SHALL have parameter COUNT_OF_BITS, default 4, giving the data word width, matching the converter output width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of buffered words; a power of two and at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  COUNT_OF_BITS  converted word from the upstream converter stage.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 bit_en  input  1  bit-rate strobe; the serial FSM advances only on cycles where it is high.
REQ-009 ser_out  output  1  registered serial line, idle high.
REQ-010 ser_busy  output  1  high while a frame is in progress (FSM not IDLE).
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of words held.
REQ-012 overflow  output  1  sticky flag: a word was offered while full.

Function
REQ-013 SHALL drive in_ready = (fifo_count < FIFO_DEPTH) combinationally from registered count.
REQ-014 SHALL push in_data when in_valid && in_ready; full FIFO SHALL reject the push even if a pop occurs the same cycle.
REQ-015 SHALL support simultaneous push and pop when not full, leaving fifo_count unchanged.
REQ-016 SHALL set overflow when in_valid && !in_ready; overflow SHALL clear only on reset.
REQ-017 FSM states: IDLE, START, DATA, STOP (plus PARITY per REQ-029).
REQ-018 IDLE: ser_out=1; on bit_en with fifo_count>0, pop the head word into the shift register and go to START.
REQ-019 START: ser_out=0; on bit_en go to DATA with bit index 0.
REQ-020 DATA: ser_out = word bit [COUNT_OF_BITS-1-index] (MSB first); on bit_en increment index; after bit index COUNT_OF_BITS-1, go to STOP.
REQ-021 STOP: ser_out=1; on bit_en, if fifo_count>0 pop and go to START (back-to-back frames, no idle bit), else go to IDLE.
REQ-022 ser_out SHALL change only in the cycle after a bit_en cycle; with bit_en low, all FSM state and ser_out SHALL hold.
REQ-023 Latency: push at cycle t into an empty FIFO with bit_en held high: word popped at t+1, start bit on ser_out at t+2, MSB at t+3, stop bit at t+3+COUNT_OF_BITS.
REQ-024 Frame length SHALL be COUNT_OF_BITS+2 bit periods (without parity).
REQ-025 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; words SHALL leave in arrival order.

Reset
REQ-026 rst high at a rising edge SHALL force: FSM=IDLE, ser_out=1, ser_busy=0, fifo_count=0, pointers=0, overflow=0, shift register and bit index=0.
REQ-027 Reset mid-frame SHALL abort the frame and discard all buffered words; no partial bits SHALL follow.
REQ-028 in_ready SHALL be 0 while rst is high.

Configuration
REQ-029 With macro CONV_SERIALIZER_PARITY_EN defined, a PARITY state SHALL follow DATA, driving the even parity bit (XOR of the word) for one bit period before STOP; frame length becomes COUNT_OF_BITS+3.
REQ-030 Without CONV_SERIALIZER_PARITY_EN, DATA SHALL go directly to STOP and no parity logic SHALL be present.

Verification (COUNT_OF_BITS=4, FIFO_DEPTH=4, bit_en=1 unless stated)
REQ-031 Single word: push 4'b1010 at cycle t -> ser_out from t+2: 0,1,0,1,0,1 then stays 1; ser_busy high t+2..t+7.
REQ-032 Back-to-back: push 4'b0001, 4'b0011, 4'b0100 on consecutive cycles -> three contiguous frames 0,0001,1 / 0,0011,1 / 0,0100,1 with no idle bit between.
REQ-033 Full and overflow: hold bit_en=0, push 5 words -> fifo_count=4, in_ready=0, 5th rejected, overflow=1 and stays 1 after draining.
REQ-034 Bit-rate gating: bit_en high every 3rd cycle, push 4'b1100 -> each ser_out bit held exactly 3 cycles, sequence 0,1,1,0,0,1.
REQ-035 Reset mid-frame: assert rst during the second data bit -> next cycle ser_out=1, ser_busy=0, fifo_count=0; no further frame without a new push.
REQ-036 Parity build: push 4'b0111 -> sequence 0,0,1,1,1,1,1 (parity bit 1 before stop).

Source files
------------

// File: rtl/conv_serializer.sv
// rtl/conv_serializer.sv - word FIFO feeding a start/data/stop serial framer; optional parity via CONV_SERIALIZER_PARITY_EN
module conv_serializer #(
    parameter int COUNT_OF_BITS = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [COUNT_OF_BITS-1:0]       in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           bit_en,
    output logic                           ser_out,
    output logic                           ser_busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = (COUNT_OF_BITS > 1) ? $clog2(COUNT_OF_BITS) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(COUNT_OF_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef CONV_SERIALIZER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [COUNT_OF_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [2:0]               state;
    logic [COUNT_OF_BITS-1:0] shreg;
    logic [IW-1:0]            idx;
    logic                     push;
    logic                     pop;

    assign in_ready = !rst && (fifo_count < DEPTH_C);
    assign push     = in_valid && in_ready;
    // A word can only leave when the framer is ready to start a new frame.
    assign pop      = bit_en && (fifo_count != '0) && (state == S_IDLE || state == S_STOP);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            shreg      <= '0;
            idx        <= '0;
            ser_out    <= 1'b1;
            ser_busy   <= 1'b0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                shreg  <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end

            // Line outputs lag the state by one cycle so each bit appears after its bit_en strobe.
            ser_busy <= (state != S_IDLE);
            case (state)
                S_START:  ser_out <= 1'b0;
                S_DATA:   ser_out <= shreg[LAST_IDX - idx];
`ifdef CONV_SERIALIZER_PARITY_EN
                S_PARITY: ser_out <= ^shreg;
`endif
                default:  ser_out <= 1'b1;
            endcase

            if (bit_en) begin
                case (state)
                    S_IDLE: begin
                        if (pop) begin
                            state <= S_START;
                        end
                    end
                    S_START: begin
                        state <= S_DATA;
                        idx   <= '0;
                    end
                    S_DATA: begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
`ifdef CONV_SERIALIZER_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
`ifdef CONV_SERIALIZER_PARITY_EN
                    S_PARITY: state <= S_STOP;
`endif
                    S_STOP: state <= pop ? S_START : S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_serializer.sv
// tb/tb_conv_serializer.sv - directed self-checking bench for conv_serializer
module tb_conv_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       bit_en;
    logic       ser_out;
    logic       ser_busy;
    logic [2:0] fifo_count;
    logic       overflow;

    int tests = 0;
    int fails = 0;

    conv_serializer #(.COUNT_OF_BITS(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bit_en     (bit_en),
        .ser_out    (ser_out),
        .ser_busy   (ser_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; bit_en = 1'b0; in_data = 4'h0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++;
        if (ser_out !== 1'b1) begin fails++; $display("FAIL reset_ser_out: got %b expected 1", ser_out); end
        tests++;
        if (ser_busy !== 1'b0) begin fails++; $display("FAIL reset_ser_busy: got %b expected 0", ser_busy); end
        tests++;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        tests++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_high: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        logic [5:0] e;
        logic       exp_out;
        logic       exp_busy;
        e = 6'b010101;
        bit_en = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            in_valid = (k == 0);
            in_data  = 4'b1010;
            tick();
            exp_out  = (k >= 2 && k <= 7) ? e[7-k] : 1'b1;
            exp_busy = (k >= 2 && k <= 7);
            tests++;
            if (ser_out !== exp_out) begin fails++; $display("FAIL single_ser_out t+%0d: got %b expected %b", k, ser_out, exp_out); end
            tests++;
            if (ser_busy !== exp_busy) begin fails++; $display("FAIL single_ser_busy t+%0d: got %b expected %b", k, ser_busy, exp_busy); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        logic [3:0]  w;
        logic        exp_out;
        logic        exp_busy;
        e = {6'b000011, 6'b000111, 6'b001001};
        bit_en = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            case (k)
                0:       w = 4'b0001;
                1:       w = 4'b0011;
                2:       w = 4'b0100;
                default: w = 4'b0000;
            endcase
            in_valid = (k < 3);
            in_data  = w;
            tick();
            exp_out  = (k >= 2 && k <= 19) ? e[19-k] : 1'b1;
            exp_busy = (k >= 2 && k <= 19);
            tests++;
            if (ser_out !== exp_out) begin fails++; $display("FAIL b2b_ser_out t+%0d: got %b expected %b", k, ser_out, exp_out); end
            tests++;
            if (ser_busy !== exp_busy) begin fails++; $display("FAIL b2b_ser_busy t+%0d: got %b expected %b", k, ser_busy, exp_busy); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_overflow();
        logic [23:0] e;
        logic [2:0]  exp_cnt;
        logic        exp_out;
        e = {6'b000011, 6'b000101, 6'b000111, 6'b001001};
        bit_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i + 1);
            tick();
            exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
            tests++;
            if (fifo_count !== exp_cnt) begin fails++; $display("FAIL full_count push%0d: got %0d expected %0d", i, fifo_count, exp_cnt); end
            tests++;
            if (in_ready !== (i < 3)) begin fails++; $display("FAIL full_in_ready push%0d: got %b expected %b", i, in_ready, (i < 3)); end
            tests++;
            if (overflow !== (i == 4)) begin fails++; $display("FAIL full_overflow push%0d: got %b expected %b", i, overflow, (i == 4)); end
            tests++;
            if (ser_busy !== 1'b0) begin fails++; $display("FAIL full_gated_busy push%0d: got %b expected 0", i, ser_busy); end
        end
        in_valid = 1'b0;
        bit_en   = 1'b1;
        for (int k = 0; k <= 25; k++) begin
            tick();
            if (k >= 1 && k <= 24) begin
                exp_out = e[24-k];
                tests++;
                if (ser_out !== exp_out) begin fails++; $display("FAIL drain_ser_out k%0d: got %b expected %b", k, ser_out, exp_out); end
            end
        end
        tests++;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL drain_count: got %0d expected 0", fifo_count); end
        tests++;
        if (ser_busy !== 1'b0) begin fails++; $display("FAIL drain_busy: got %b expected 0", ser_busy); end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_gating();
        logic exp_out;
        logic exp_busy;
        for (int c = 0; c <= 24; c++) begin
            bit_en   = (c % 3 == 0);
            in_valid = (c == 0);
            in_data  = 4'b1100;
            tick();
            exp_out  = !((c >= 4 && c <= 6) || (c >= 13 && c <= 18));
            exp_busy = (c >= 4 && c <= 21);
            tests++;
            if (ser_out !== exp_out) begin fails++; $display("FAIL gating_ser_out c%0d: got %b expected %b", c, ser_out, exp_out); end
            tests++;
            if (ser_busy !== exp_busy) begin fails++; $display("FAIL gating_ser_busy c%0d: got %b expected %b", c, ser_busy, exp_busy); end
        end
        in_valid = 1'b0;
        bit_en   = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        bit_en = 1'b1;
        in_valid = 1'b1; in_data = 4'b1010;
        tick();
        in_data = 4'b0110;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        tests++;
        if (ser_out !== 1'b0) begin fails++; $display("FAIL midrst_second_bit: got %b expected 0", ser_out); end
        tests++;
        if (fifo_count !== 3'd1) begin fails++; $display("FAIL midrst_pending: got %0d expected 1", fifo_count); end
        rst = 1'b1;
        tick();
        tests++;
        if (ser_out !== 1'b1) begin fails++; $display("FAIL midrst_ser_out: got %b expected 1", ser_out); end
        tests++;
        if (ser_busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b expected 0", ser_busy); end
        tests++;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL midrst_count: got %0d expected 0", fifo_count); end
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            tests++;
            if (ser_out !== 1'b1 || ser_busy !== 1'b0) begin
                fails++;
                $display("FAIL midrst_quiet k%0d: got ser_out=%b busy=%b expected 1/0", k, ser_out, ser_busy);
            end
        end
    endtask

    task automatic test_parity();
        int   last_busy;
        logic exp_out;
        logic exp_busy;
`ifdef CONV_SERIALIZER_PARITY_EN
        last_busy = 8;
`else
        last_busy = 7;
`endif
        bit_en = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            in_valid = (k == 0);
            in_data  = 4'b0111;
            tick();
            exp_out  = !(k == 2 || k == 3);
            exp_busy = (k >= 2 && k <= last_busy);
            tests++;
            if (ser_out !== exp_out) begin fails++; $display("FAIL parity_ser_out t+%0d: got %b expected %b", k, ser_out, exp_out); end
            tests++;
            if (ser_busy !== exp_busy) begin fails++; $display("FAIL parity_ser_busy t+%0d: got %b expected %b", k, ser_busy, exp_busy); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; bit_en = 1'b0; in_data = 4'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_full_overflow();
        test_reset();
        test_gating();
        test_reset_mid_frame();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
